mult_result_bcd: RTL

- Sequential binary-to-BCD converter on the downstream side of the 8-bit multiply stage.
- Captures the multiplier's 8-bit `out` on a start strobe and converts it with shift-add-3 (double dabble), one bit per clock.
- Presents packed BCD digits to the calculator's 7-segment display driver.
- Start/busy/done handshake lets the display logic request a conversion only when the product changes.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/mult_result_bcd.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, FSM state encoding and count width helper for the BCD converter
package calc_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of a counter that must hold the values 0..width inclusive.
  function automatic int count_w(input int width);
    if (width < 1) begin
      return 1;
    end
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational double-dabble digit correction (add 3 when digit >= 5)
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // A digit of 5 or more would exceed 9 after doubling, so pre-bias it by 3.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_DIGIT_W'(5)) begin
      o_digit = i_digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/mult_result_bcd.sv
// rtl/mult_result_bcd.sv - sequential binary-to-BCD converter for the multiply result; optional MULT_RESULT_BCD_SIGNED_EN
module mult_result_bcd
  import calc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          neg
);

  localparam int CNT_W = count_w(WIDTH);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd;

  logic [WIDTH-1:0]   w_mag;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W+WIDTH-1:0] w_cat;
  logic [BCD_W-1:0]   w_scratch_nxt;
  logic [WIDTH-1:0]   w_shift_nxt;

`ifdef MULT_RESULT_BCD_SIGNED_EN
  logic               w_sign;
  logic               r_sign;
  logic               r_neg;

  // Two's complement input: convert the magnitude, remember the sign separately.
  // The most negative value negates to itself, which read unsigned is its magnitude.
  assign w_sign = bin[WIDTH-1];
  assign w_mag  = w_sign ? (~bin + WIDTH'(1)) : bin;
  assign neg    = r_neg;
`else
  assign w_mag  = bin;
  assign neg    = 1'b0;
`endif

  // Per-digit add-3 correction applied to the scratch BCD before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_cat         = {w_adj, r_shift} << 1;
  assign w_scratch_nxt = w_cat[BCD_W+WIDTH-1:WIDTH];
  assign w_shift_nxt   = w_cat[WIDTH-1:0];

  // State register; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs; DONE accepts a new start just like IDLE.
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end else begin
          w_next   = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Shift datapath and result registers; results only load on the final shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
`ifdef MULT_RESULT_BCD_SIGNED_EN
      r_sign    <= 1'b0;
      r_neg     <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_shift   <= w_mag;
        r_scratch <= '0;
        r_cnt     <= '0;
`ifdef MULT_RESULT_BCD_SIGNED_EN
        r_sign    <= w_sign;
`endif
      end else if (r_state == SHIFT) begin
        r_shift   <= w_shift_nxt;
        r_scratch <= w_scratch_nxt;
        r_cnt     <= r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_bcd <= w_scratch_nxt;
`ifdef MULT_RESULT_BCD_SIGNED_EN
        r_neg <= r_sign;
`endif
      end
    end
  end

  assign bcd = r_bcd;

endmodule
